// File: rtl/jtpopeye_dma_pkg.sv
// Shared state encoding and window defaults for the Popeye object DMA.
package jtpopeye_dma_pkg;

    localparam int         DMA_WIN   = 1024;
    localparam logic [9:0] DMA_START = 10'h000;
    localparam int         DMA_LEN   = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_COPY,
        ST_FLUSH,
        ST_REL
    } dma_state_e;

endpackage

// File: rtl/jtpopeye_dma_addr.sv
// Window address counter, issued-byte counter and write-pipeline valid flag.
module jtpopeye_dma_addr
    import jtpopeye_dma_pkg::*;
#(
    parameter logic [9:0] START = DMA_START,
    parameter int         LEN   = DMA_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       load,
    input  logic       adv,
    input  logic       vclr,
    output logic [9:0] addr,
    output logic [9:0] idx,
    output logic       v,
    output logic       tc
);

    localparam int          CW   = $clog2(DMA_WIN) + 1;
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    logic [9:0]    addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          v_q, v_d;

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        v_d    = v_q;
        if (load) begin
            addr_d = START;
            cnt_d  = '0;
            v_d    = 1'b0;
        end else if (adv) begin
            addr_d = addr_q + 10'd1;
            cnt_d  = cnt_q + 1'b1;
            v_d    = 1'b1;
        end else if (vclr) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= START;
            cnt_q  <= '0;
            v_q    <= 1'b0;
        end else if (cen) begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            v_q    <= v_d;
        end
    end

    // The byte being written belongs to the previous address (RAM latency 1).
    assign addr = addr_q;
    assign idx  = addr_q - 10'd1 - START;
    assign v    = v_q;
    assign tc   = (cnt_q == LAST);

endmodule

// File: rtl/jtpopeye_dma.sv
// Popeye object DMA: on VB rising edge, borrow the Z80 bus and copy a RAM window into the back object bank.
module jtpopeye_dma
    import jtpopeye_dma_pkg::*;
#(
    parameter logic [9:0] START  = DMA_START,
    parameter int         LEN    = DMA_LEN,
    parameter int         OBJ_AW = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic              VB,
    input  logic              busak_n,
    output logic              busrq_n,
    output logic              dma_cs,
    output logic [9:0]        AD_DMA,
    input  logic [7:0]        DD_DMA,
    output logic              obj_we,
    output logic [OBJ_AW-1:0] obj_addr,
    output logic [7:0]        obj_data,
    output logic              rd_bank,
    output logic              busy,
    output logic              done
);

    dma_state_e state_q, state_d;
    logic       vbl_q, busrq_n_q, busrq_n_d, dma_cs_q, dma_cs_d;
    logic       wr_bank_q, wr_bank_d, held_q, held_d;
    logic [7:0] hold_q, hold_d;
    logic       load, adv, vclr, v, tc, trig;
    logic [9:0] idx;

    jtpopeye_dma_addr #(
        .START (START),
        .LEN   (LEN)
    ) u_addr (
        .clk   (clk),
        .rst   (rst),
        .cen   (cen),
        .load  (load),
        .adv   (adv),
        .vclr  (vclr),
        .addr  (AD_DMA),
        .idx   (idx),
        .v     (v),
        .tc    (tc)
    );

    assign trig = VB && !vbl_q;

    always_comb begin
        state_d   = state_q;
        busrq_n_d = busrq_n_q;
        dma_cs_d  = dma_cs_q;
        wr_bank_d = wr_bank_q;
        held_d    = held_q;
        hold_d    = hold_q;
        load      = 1'b0;
        adv       = 1'b0;
        vclr      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busrq_n_d = 1'b1;
                if (trig) begin
                    state_d   = ST_REQ;
                    busrq_n_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (!busak_n) begin
                    dma_cs_d = 1'b1;
                    load     = 1'b1;
                    state_d  = ST_COPY;
                end
            end
            ST_COPY, ST_FLUSH: begin
                // Bus lost: keep the pending byte, since DD_DMA moves on to the next address.
                if (busak_n) begin
                    held_d = 1'b1;
                    if (!held_q) hold_d = DD_DMA;
                end else begin
                    held_d = 1'b0;
                    if (state_q == ST_COPY) begin
                        adv = 1'b1;
                        if (tc) state_d = ST_FLUSH;
                    end else begin
                        vclr      = 1'b1;
                        dma_cs_d  = 1'b0;
                        busrq_n_d = 1'b1;
                        state_d   = ST_REL;
                    end
                end
            end
            ST_REL: begin
                if (busak_n) begin
                    wr_bank_d = ~wr_bank_q;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            vbl_q     <= 1'b0;
            busrq_n_q <= 1'b1;
            dma_cs_q  <= 1'b0;
            wr_bank_q <= 1'b0;
            held_q    <= 1'b0;
        end else if (cen) begin
            state_q   <= state_d;
            vbl_q     <= VB;
            busrq_n_q <= busrq_n_d;
            dma_cs_q  <= dma_cs_d;
            wr_bank_q <= wr_bank_d;
            held_q    <= held_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cen) hold_q <= hold_d;
    end

    assign busrq_n  = busrq_n_q;
    assign dma_cs   = dma_cs_q;
    assign rd_bank  = ~wr_bank_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_REL) && busak_n && cen;
    assign obj_we   = v && cen && !busak_n && (state_q == ST_COPY || state_q == ST_FLUSH);
    assign obj_addr = v ? OBJ_AW'({wr_bank_q, idx}) : '0;
    assign obj_data = v ? (held_q ? hold_q : DD_DMA) : 8'd0;

endmodule

// File: tb/tb_jtpopeye_dma.sv
// Bench for jtpopeye_dma: three window configurations, RAM and bus-ack models, write scoreboard.
module tb_jtpopeye_dma;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b0;
    logic       vb[N];
    logic       busak_n[N];
    logic       busrq_n[N];
    logic       dma_cs[N];
    logic [9:0] ad[N];
    logic [7:0] dd[N];
    logic       obj_we[N];
    logic [10:0] oa[N];
    logic [7:0] od[N];
    logic       rd_bank[N];
    logic       busy[N];
    logic       done[N];

    logic [2:0] ak_sr[N];
    logic       force_hi[N];
    logic       exp_bank[N];
    logic       wrap_seen[N];
    logic [9:0] prev_ad[N];
    int         wr_cnt[N];
    int         done_cnt[N];
    int         n_chk = 0;
    int         n_pass = 0;
    logic [20:0] exp_q[$];
    logic [20:0] mon_got, mon_exp;

    jtpopeye_dma #(.START(10'h000), .LEN(1024), .OBJ_AW(11)) dut0 (
        .clk(clk), .rst(rst), .cen(cen), .VB(vb[0]), .busak_n(busak_n[0]), .busrq_n(busrq_n[0]),
        .dma_cs(dma_cs[0]), .AD_DMA(ad[0]), .DD_DMA(dd[0]), .obj_we(obj_we[0]), .obj_addr(oa[0]),
        .obj_data(od[0]), .rd_bank(rd_bank[0]), .busy(busy[0]), .done(done[0]));
    jtpopeye_dma #(.START(10'h300), .LEN(256), .OBJ_AW(11)) dut1 (
        .clk(clk), .rst(rst), .cen(cen), .VB(vb[1]), .busak_n(busak_n[1]), .busrq_n(busrq_n[1]),
        .dma_cs(dma_cs[1]), .AD_DMA(ad[1]), .DD_DMA(dd[1]), .obj_we(obj_we[1]), .obj_addr(oa[1]),
        .obj_data(od[1]), .rd_bank(rd_bank[1]), .busy(busy[1]), .done(done[1]));
    jtpopeye_dma #(.START(10'h3F0), .LEN(32), .OBJ_AW(11)) dut2 (
        .clk(clk), .rst(rst), .cen(cen), .VB(vb[2]), .busak_n(busak_n[2]), .busrq_n(busrq_n[2]),
        .dma_cs(dma_cs[2]), .AD_DMA(ad[2]), .DD_DMA(dd[2]), .obj_we(obj_we[2]), .obj_addr(oa[2]),
        .obj_data(od[2]), .rd_bank(rd_bank[2]), .busy(busy[2]), .done(done[2]));

    function automatic logic [9:0] st_of(input int k);
        case (k)
            0:       return 10'h000;
            1:       return 10'h300;
            default: return 10'h3F0;
        endcase
    endfunction

    function automatic int len_of(input int k);
        case (k)
            0:       return 1024;
            1:       return 256;
            default: return 32;
        endcase
    endfunction

    always #5 clk = ~clk;

    // cen changes just after each rising edge so it is stable for the whole following period.
    initial forever begin
        @(posedge clk);
        #1 cen = ~cen;
    end

    always @(posedge clk) begin
        if (cen) for (int k = 0; k < N; k++) dd[k] <= ad[k][7:0] ^ 8'h5A;
    end

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < N; k++) begin
            if (rst) ak_sr[k] <= 3'b111;
            else if (cen) ak_sr[k] <= {ak_sr[k][1:0], busrq_n[k]};
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) busak_n[k] = ak_sr[k][2] | force_hi[k];
    end

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (prev_ad[k] == 10'h3FF && ad[k] == 10'h000) wrap_seen[k] = 1'b1;
            prev_ad[k] = ad[k];
            if (done[k]) done_cnt[k]++;
            if (obj_we[k]) begin
                wr_cnt[k]++;
                n_chk++;
                mon_got = {2'(k), oa[k], od[k]};
                if (exp_q.size() == 0) begin
                    $display("FAIL obj_write_unexpected dut%0d got=%h expected none", k, mon_got);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp)
                        $display("FAIL obj_write dut%0d got=%h exp=%h", k, mon_got, mon_exp);
                    else
                        n_pass++;
                end
            end
        end
    end

    task automatic cen_tick();
        logic c;
        c = 1'b0;
        while (!c) begin
            @(posedge clk);
            c = cen;
        end
        #2;
    endtask

    task automatic push_frame(input int k);
        logic [9:0] a;
        for (int i = 0; i < len_of(k); i++) begin
            a = st_of(k) + 10'(i);
            exp_q.push_back({2'(k), exp_bank[k], 10'(i), a[7:0] ^ 8'h5A});
        end
    endtask

    task automatic wait_done(input int k, input int d0, output bit timeout);
        int t;
        t = 0;
        while (done_cnt[k] == d0 && t < 4000) begin
            cen_tick();
            t++;
        end
        timeout = (t >= 4000);
    endtask

    task automatic wait_writes(input int k, input int target, output bit timeout);
        int t;
        t = 0;
        while (wr_cnt[k] < target && t < 4000) begin
            cen_tick();
            t++;
        end
        timeout = (t >= 4000);
    endtask

    task automatic test_reset();
        repeat (3) cen_tick();
        for (int k = 0; k < N; k++) begin
            n_chk++;
            if ({busrq_n[k], dma_cs[k], obj_we[k], rd_bank[k], busy[k], done[k]} !== 6'b100100)
                $display("FAIL reset_ctrl dut%0d got=%b exp=100100", k,
                         {busrq_n[k], dma_cs[k], obj_we[k], rd_bank[k], busy[k], done[k]});
            else n_pass++;
            n_chk++;
            if ({ad[k], oa[k], od[k]} !== {st_of(k), 11'd0, 8'd0})
                $display("FAIL reset_data dut%0d got=%h exp=%h", k, {ad[k], oa[k], od[k]},
                         {st_of(k), 11'd0, 8'd0});
            else n_pass++;
        end
        rst = 1'b0;
        repeat (3) cen_tick();
        n_chk++;
        if (busy[0] !== 1'b0) $display("FAIL idle_after_reset got=%b exp=0", busy[0]);
        else n_pass++;
    endtask

    task automatic test_full_frame();
        int d0, t;
        bit to;
        push_frame(0);
        wr_cnt[0] = 0;
        d0 = done_cnt[0];
        vb[0] = 1'b1;
        n_chk++;
        if (busrq_n[0] !== 1'b1) $display("FAIL busrq_before_edge got=%b exp=1", busrq_n[0]);
        else n_pass++;
        cen_tick();
        n_chk++;
        if ({busrq_n[0], busy[0]} !== 2'b01)
            $display("FAIL busrq_after_edge got=%b exp=01", {busrq_n[0], busy[0]});
        else n_pass++;
        t = 0;
        while (busak_n[0] && t < 20) begin
            cen_tick();
            t++;
        end
        cen_tick();
        n_chk++;
        if (dma_cs[0] !== 1'b1 || t >= 20) $display("FAIL dma_cs_after_ack got=%b exp=1 wait=%0d", dma_cs[0], t);
        else n_pass++;
        wait_done(0, d0, to);
        exp_bank[0] = ~exp_bank[0];
        n_chk++;
        if (to) $display("FAIL full_frame_done_timeout got=timeout exp=done");
        else n_pass++;
        n_chk++;
        if (wr_cnt[0] !== 1024 || exp_q.size() !== 0)
            $display("FAIL full_frame_count got=%0d left=%0d exp=1024 left=0", wr_cnt[0], exp_q.size());
        else n_pass++;
        n_chk++;
        if ({rd_bank[0], busy[0], dma_cs[0], busrq_n[0]} !== {~exp_bank[0], 3'b001})
            $display("FAIL full_frame_end got=%b exp=%b", {rd_bank[0], busy[0], dma_cs[0], busrq_n[0]},
                     {~exp_bank[0], 3'b001});
        else n_pass++;
        vb[0] = 1'b0;
        cen_tick();
    endtask

    task automatic test_window(input int k, input string nm);
        int d0;
        bit to;
        push_frame(k);
        wr_cnt[k] = 0;
        wrap_seen[k] = 1'b0;
        d0 = done_cnt[k];
        vb[k] = 1'b1;
        wait_done(k, d0, to);
        exp_bank[k] = ~exp_bank[k];
        n_chk++;
        if (to || wr_cnt[k] !== len_of(k) || exp_q.size() !== 0)
            $display("FAIL %s_count got=%0d left=%0d exp=%0d left=0", nm, wr_cnt[k], exp_q.size(), len_of(k));
        else n_pass++;
        n_chk++;
        if (rd_bank[k] !== ~exp_bank[k]) $display("FAIL %s_rd_bank got=%b exp=%b", nm, rd_bank[k], ~exp_bank[k]);
        else n_pass++;
        if (k == 2) begin
            n_chk++;
            if (wrap_seen[2] !== 1'b1) $display("FAIL wrap_3ff_to_000 got=%b exp=1", wrap_seen[2]);
            else n_pass++;
        end
        vb[k] = 1'b0;
        cen_tick();
    endtask

    task automatic test_bus_loss();
        int d0, c0;
        bit to;
        push_frame(1);
        wr_cnt[1] = 0;
        d0 = done_cnt[1];
        vb[1] = 1'b1;
        wait_writes(1, 100, to);
        force_hi[1] = 1'b1;
        c0 = wr_cnt[1];
        repeat (5) cen_tick();
        n_chk++;
        if (to || wr_cnt[1] !== c0) $display("FAIL gap_no_writes got=%0d exp=%0d", wr_cnt[1], c0);
        else n_pass++;
        n_chk++;
        if (busrq_n[1] !== 1'b0) $display("FAIL gap_busrq_held got=%b exp=0", busrq_n[1]);
        else n_pass++;
        force_hi[1] = 1'b0;
        wait_done(1, d0, to);
        exp_bank[1] = ~exp_bank[1];
        n_chk++;
        if (to || wr_cnt[1] !== 256 || exp_q.size() !== 0)
            $display("FAIL gap_total got=%0d left=%0d exp=256 left=0", wr_cnt[1], exp_q.size());
        else n_pass++;
        vb[1] = 1'b0;
        cen_tick();
    endtask

    task automatic test_back_to_back();
        int d0;
        bit to;
        push_frame(2);
        wr_cnt[2] = 0;
        d0 = done_cnt[2];
        vb[2] = 1'b1;
        wait_writes(2, 10, to);
        vb[2] = 1'b0;
        repeat (2) cen_tick();
        vb[2] = 1'b1;
        wait_done(2, d0, to);
        exp_bank[2] = ~exp_bank[2];
        repeat (20) cen_tick();
        n_chk++;
        if (to || done_cnt[2] !== d0 + 1) $display("FAIL b2b_done_count got=%0d exp=%0d", done_cnt[2], d0 + 1);
        else n_pass++;
        n_chk++;
        if ({busy[2], busrq_n[2], rd_bank[2]} !== {2'b01, ~exp_bank[2]})
            $display("FAIL b2b_idle got=%b exp=%b", {busy[2], busrq_n[2], rd_bank[2]}, {2'b01, ~exp_bank[2]});
        else n_pass++;
        n_chk++;
        if (wr_cnt[2] !== 32 || exp_q.size() !== 0)
            $display("FAIL b2b_writes got=%0d left=%0d exp=32 left=0", wr_cnt[2], exp_q.size());
        else n_pass++;
        vb[2] = 1'b0;
        cen_tick();
    endtask

    task automatic test_reset_mid();
        int d0;
        bit to;
        push_frame(0);
        wr_cnt[0] = 0;
        d0 = done_cnt[0];
        vb[0] = 1'b1;
        wait_writes(0, 500, to);
        rst = 1'b1;
        #1;
        n_chk++;
        if (to || {busrq_n[0], dma_cs[0], rd_bank[0], busy[0]} !== 4'b1010)
            $display("FAIL reset_mid_release got=%b exp=1010", {busrq_n[0], dma_cs[0], rd_bank[0], busy[0]});
        else n_pass++;
        vb[0] = 1'b0;
        exp_q.delete();
        for (int k = 0; k < N; k++) exp_bank[k] = 1'b0;
        repeat (2) cen_tick();
        rst = 1'b0;
        repeat (2) cen_tick();
        n_chk++;
        if (done_cnt[0] !== d0) $display("FAIL reset_mid_no_done got=%0d exp=%0d", done_cnt[0], d0);
        else n_pass++;
        push_frame(0);
        wr_cnt[0] = 0;
        vb[0] = 1'b1;
        wait_done(0, d0, to);
        exp_bank[0] = ~exp_bank[0];
        n_chk++;
        if (to || wr_cnt[0] !== 1024 || exp_q.size() !== 0 || rd_bank[0] !== ~exp_bank[0])
            $display("FAIL reset_restart got=%0d left=%0d rd=%b exp=1024 left=0 rd=%b",
                     wr_cnt[0], exp_q.size(), rd_bank[0], ~exp_bank[0]);
        else n_pass++;
        vb[0] = 1'b0;
        cen_tick();
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            vb[k] = 1'b0;
            force_hi[k] = 1'b0;
            exp_bank[k] = 1'b0;
            wrap_seen[k] = 1'b0;
            prev_ad[k] = 10'h000;
            wr_cnt[k] = 0;
            done_cnt[k] = 0;
        end
        test_reset();
        test_full_frame();
        test_window(1, "window_300");
        test_window(2, "wrap_3f0");
        test_bus_loss();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jtpopeye_dma.md
Name: jtpopeye_dma

Overview:
- Sprite/object DMA engine for the Popeye main board.
- On each vertical-blank rising edge it requests the Z80 bus (busrq_n), waits for busak_n, then copies a window of the upper 1 KB of main work RAM into a double-buffered object RAM.
- It drives dma_cs/AD_DMA into the main CPU block and consumes DD_DMA. The video object renderer reads the inactive bank while the next frame is copied.

Parameters:
- START, 10'h000, first word address within the 1 KB DMA window.
- LEN, 11'd1024, number of bytes copied per frame (1..1024); START+LEN-1 wraps mod 1024.
- OBJ_AW, 11, object RAM address width: {bank, 10-bit index}.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cen  in  1  CPU clock enable (same enable as the main RAM)
- VB  in  1  vertical blank
- busak_n  in  1  Z80 bus acknowledge, active low
- busrq_n  out  1  Z80 bus request, active low
- dma_cs  out  1  high while the DMA owns the RAM address mux
- AD_DMA  out  10  RAM address within the upper 1 KB
- DD_DMA  in  8  RAM read data, registered, valid one cen after address
- obj_we  out  1  object RAM write strobe, one clk wide, coincident with cen
- obj_addr  out  OBJ_AW  {wr_bank, index}
- obj_data  out  8  byte to write
- rd_bank  out  1  bank the renderer must read (= ~wr_bank)
- busy  out  1  high from REQ entry to IDLE return
- done  out  1  one-clk pulse (on cen) when a full copy completes

Behaviour:
- Reset values:
  - busrq_n=1, dma_cs=0, AD_DMA=START, obj_we=0, obj_addr=0, obj_data=0.
  - wr_bank=0, so rd_bank=1. busy=0, done=0, state=IDLE.
- All state updates occur on clk edges with cen=1, except that the async reset acts immediately.
- VB edge detection: VBl is registered on cen. A trigger occurs when VB && !VBl.
- States:
  - IDLE: busrq_n=1. On a trigger, go to REQ.
  - REQ: busrq_n=0. When busak_n=0 is sampled, set dma_cs=1 and AD_DMA=START, clear cnt, and go to COPY.
  - COPY: on each cen, AD_DMA <= AD_DMA+1 (mod 1024) and cnt++.
    - A pipeline valid flag v is set one cen after the first address. While v=1: obj_we=1, obj_data=DD_DMA, obj_addr={wr_bank, (AD_DMA-1-START) mod 1024}.
    - When cnt==LEN-1 has been issued, go to FLUSH.
  - FLUSH: write the final byte (latency 1), drop dma_cs, set busrq_n=1, and go to REL.
  - REL: wait for busak_n=1. Then toggle wr_bank, pulse done, and go to IDLE.
- Timing: total bytes written per frame = LEN exactly. The first obj_we occurs 1 cen after the first address. The bus is held for LEN+2 cen cycles after acknowledge.
- busak_n rising during COPY (bus lost): freeze AD_DMA, cnt and the pipeline, and keep obj_we=0. Resume when busak_n=0 again. busrq_n stays 0.
- A trigger while busy is ignored. No queueing.
- VB falling mid-copy has no effect; the copy runs to completion.
- Reset mid-operation releases the bus in the same cycle (busrq_n=1, dma_cs=0). No partial bank flip.
- LEN=1024 with START≠0 wraps AD_DMA through 0x3FF→0x000. The object index is always 0..LEN-1.

Decomposition:
- Shared package: state encoding (IDLE, REQ, COPY, FLUSH, REL), DMA window size constant 1024, default START/LEN.
- Optional sub-module jtpopeye_dma_addr: address counter, byte counter and pipeline-valid flag, with increment, freeze and terminal-count outputs. The FSM stays in the top module.

Test Plan:
- Reset then VB 0→1 with busak_n tied to busrq_n delayed 3 cen → busrq_n low 1 cen after the edge; dma_cs high after acknowledge; 1024 obj_we pulses with addresses {0,0x000}..{0,0x3FF}; done pulse; rd_bank 1→0.
- RAM model with data=addr[7:0]^0x5A and LEN=256, START=10'h300 → obj_data at index i equals (0x300+i)[7:0]^0x5A; AD_DMA never exceeds 0x3FF.
- START=10'h3F0, LEN=32 → AD_DMA wraps 0x3FF→0x000; indices 0..31 are all written exactly once.
- busak_n raised for 5 cen in mid-COPY at cnt=100 → no obj_we during the gap; resume at index 100; total write count still LEN.
- Second VB edge injected during COPY → ignored; exactly one done; wr_bank toggles once.
- rst asserted at cnt=500 → busrq_n=1 and dma_cs=0 immediately; wr_bank=0; a following VB restarts from index 0.
